// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: collects WIDTH serial bits into a word with a valid/ready output.
// Optional even-parity bit after the data bits when PARITY_CHECK_EN is defined.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   START           begins or restarts a word (same-cycle BIT_VALID becomes bit 0)
//   SER_DATA        serial bit, sampled when BIT_VALID=1
//   BIT_VALID       one bit per high cycle
//   D_OUT           assembled word, stable while OUT_VALID=1
//   OUT_VALID       word available (HOLD state)
//   OUT_READY       consumer accepts word when OUT_VALID and OUT_READY are high
//   BUSY            high while shifting data (or waiting for the parity bit)
//   BIT_CNT         data bits received in the current word
//   OVERRUN         sticky: a bit or START arrived in HOLD without a handshake
//   PARITY_ERR      parity result, meaningful only while OUT_VALID=1 (0 without PARITY_CHECK_EN)
module serial_word_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic                       SER_DATA,
    input  logic                       BIT_VALID,
    output logic [WIDTH-1:0]           D_OUT,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic                       BUSY,
    output logic [$clog2(WIDTH+1)-1:0] BIT_CNT,
    output logic                       OVERRUN,
    output logic                       PARITY_ERR
);

    localparam int CW = $clog2(WIDTH+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd3;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] S_PAR   = 2'd2;
    localparam logic [1:0] S_DONE  = S_PAR;
`else
    localparam logic [1:0] S_DONE  = S_HOLD;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             restart;
    logic [WIDTH-1:0] shifted;

    // LSB_FIRST shifts right so the first bit ends in [0];
    // otherwise shift left so the first bit ends in [WIDTH-1].
    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] r,
        input logic             b
    );
        if (LSB_FIRST) begin
            return {b, r[WIDTH-1:1]};
        end else begin
            return {r[WIDTH-2:0], b};
        end
    endfunction

    // START restarts everywhere except in HOLD, where it only
    // counts when it coincides with the handshake.
    assign restart = START && ((state_q != S_HOLD) || OUT_READY);
    assign shifted = shift_in(sreg_q, SER_DATA);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        perr_d  = perr_q;

        if (restart) begin
            state_d = S_SHIFT;
            sreg_d  = BIT_VALID ? shift_in('0, SER_DATA) : '0;
            cnt_d   = {{(CW-1){1'b0}}, BIT_VALID};
            perr_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_SHIFT: begin
                    if (BIT_VALID) begin
                        sreg_d = shifted;
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            dout_d  = shifted;
                            state_d = S_DONE;
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                S_PAR: begin
                    if (BIT_VALID) begin
                        perr_d  = (^dout_q) ^ SER_DATA;
                        state_d = S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (OUT_READY) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end else if (BIT_VALID || START) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign D_OUT     = dout_q;
    assign OUT_VALID = (state_q == S_HOLD);
    assign BIT_CNT   = cnt_q;
    assign OVERRUN   = ovr_q;
`ifdef PARITY_CHECK_EN
    assign BUSY       = (state_q == S_SHIFT) || (state_q == S_PAR);
    assign PARITY_ERR = perr_q;
`else
    assign BUSY       = (state_q == S_SHIFT);
    assign PARITY_ERR = 1'b0;
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: scoreboard bench for serial_word_deserializer.
// Two instances (LSB_FIRST=1 and 0) share one stimulus stream.
module tb_serial_word_deserializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       SER_DATA;
    logic       BIT_VALID;
    logic       OUT_READY;

    logic [3:0] d1, d0;
    logic       ov1, ov0;
    logic       busy1, busy0;
    logic [2:0] cnt1, cnt0;
    logic       orun1, orun0;
    logic       perr1, perr0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d0;
        logic       p;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    serial_word_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(CLK), .RST(RST), .START(START), .SER_DATA(SER_DATA),
        .BIT_VALID(BIT_VALID), .D_OUT(d1), .OUT_VALID(ov1),
        .OUT_READY(OUT_READY), .BUSY(busy1), .BIT_CNT(cnt1),
        .OVERRUN(orun1), .PARITY_ERR(perr1)
    );

    serial_word_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .CLK(CLK), .RST(RST), .START(START), .SER_DATA(SER_DATA),
        .BIT_VALID(BIT_VALID), .D_OUT(d0), .OUT_VALID(ov0),
        .OUT_READY(OUT_READY), .BUSY(busy0), .BIT_CNT(cnt0),
        .OVERRUN(orun0), .PARITY_ERR(perr0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // bits[i] is the i-th bit on the wire
    task automatic push_exp(input logic [3:0] bits, input logic pbit);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.d1[i]   = bits[i];
            e.d0[3-i] = bits[i];
        end
`ifdef PARITY_CHECK_EN
        e.p = (^bits) ^ pbit;
`else
        e.p = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic st, input logic b);
        START     = st;
        BIT_VALID = 1'b1;
        SER_DATA  = b;
        tick();
        START     = 1'b0;
        BIT_VALID = 1'b0;
        SER_DATA  = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] bits, input int gap,
                             input logic pbit);
        push_exp(bits, pbit);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (gap) tick();
            drive_bit(i == 0, bits[i]);
            if (i < 3) begin
                check("cnt_shift", cnt1, i + 1);
                check("busy_shift", busy1, 1);
            end
        end
`ifdef PARITY_CHECK_EN
        repeat (gap) tick();
        drive_bit(1'b0, pbit);
`endif
    endtask

    // called the cycle after the last bit edge: checks 1-cycle latency
    task automatic check_word();
        exp_t e;
        check("valid_lsb", ov1, 1);
        check("valid_msb", ov0, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("dout_lsb", d1, e.d1);
            check("dout_msb", d0, e.d0);
            check("perr", perr1, e.p);
        end
        check("cnt_hold", cnt1, 4);
        check("busy_hold", busy1, 0);
    endtask

    task automatic handshake();
        logic [3:0] keep;
        keep      = d1;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("valid_after_hs", ov1, 0);
        check("cnt_after_hs", cnt1, 0);
        check("dout_kept", d1, keep);
    endtask

    initial begin
        RST       = 1'b1;
        START     = 1'b0;
        SER_DATA  = 1'b0;
        BIT_VALID = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) tick();
        check("rst_dout", d1, 0);
        check("rst_valid", ov1, 0);
        check("rst_busy", busy1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_ovr", orun1, 0);
        check("rst_perr", perr1, 0);
        RST = 1'b0;
        tick();

        // stray bit in IDLE is ignored
        drive_bit(1'b0, 1'b1);
        check("idle_ovr", orun1, 0);
        check("idle_busy", busy1, 0);
        check("idle_cnt", cnt1, 0);

        send_word(4'b0001, 0, 1'b1);
        check_word();
        handshake();

        send_word(4'b1010, 0, 1'b0);
        check_word();
        handshake();

        // gapped bits, then stall with an overrunning bit in HOLD
        send_word(4'b1111, 3, 1'b0);
        check_word();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                BIT_VALID = 1'b1;
                SER_DATA  = 1'b0;
            end
            tick();
            BIT_VALID = 1'b0;
            check("hold_dout", d1, 4'b1111);
            check("hold_valid", ov1, 1);
        end
        check("ovr_set", orun1, 1);
        handshake();
        check("ovr_sticky", orun1, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst2_dout", d1, 0);
        check("rst2_ovr", orun1, 0);
        check("rst2_valid", ov1, 0);

        // restart after two bits
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        send_word(4'b1010, 0, 1'b0);
        check_word();
        check("restart_ovr", orun1, 0);
        handshake();

        // reset mid-word
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_cnt", cnt1, 0);
        check("midrst_busy", busy1, 0);
        tick();
        check("midrst_valid", ov1, 0);

        // back-to-back: START + bit 0 of word 2 on the handshake
        send_word(4'b1011, 0, 1'b1);
        check_word();
        push_exp(4'b0110, 1'b0);
        OUT_READY = 1'b1;
        START     = 1'b1;
        BIT_VALID = 1'b1;
        SER_DATA  = 1'b0;
        tick();
        OUT_READY = 1'b0;
        START     = 1'b0;
        BIT_VALID = 1'b0;
        check("b2b_valid", ov1, 0);
        check("b2b_cnt", cnt1, 1);
        check("b2b_busy", busy1, 1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        drive_bit(1'b0, 1'b0);
`endif
        check_word();
        check("b2b_ovr", orun1, 0);
        handshake();

        // parity good then bad (expects 0 without the feature)
        send_word(4'b0011, 0, 1'b0);
        check_word();
        handshake();
        send_word(4'b0011, 0, 1'b1);
        check_word();
        handshake();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
